// File: rtl/ddr3_word_port.sv
// Single-word (32-bit) request port onto the MIG native app_* interface.
// One transaction in flight; write data replicated across lanes with a per-lane byte mask.
module ddr3_word_port #(
  parameter int WADDR_W    = 27,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic               ui_clk,
  input  logic               ui_clk_sync_rst,
  input  logic               init_calib_complete,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WADDR_W-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  input  logic [3:0]         req_be,
  output logic               rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               fault,
  output logic [27:0]        app_addr,
  output logic [2:0]         app_cmd,
  output logic               app_en,
  input  logic               app_rdy,
  output logic [127:0]       app_wdf_data,
  output logic [15:0]        app_wdf_mask,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  input  logic               app_wdf_rdy,
  input  logic [127:0]       app_rd_data,
  input  logic               app_rd_data_valid
);

  localparam int TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR, RD_CMD, RD_WAIT} state_t;

  state_t             state_reg, state_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [1:0]         lane_reg, lane_next;
  logic               fault_reg, fault_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic               rsp_err_reg, rsp_err_next;
  logic [31:0]        rsp_rdata_reg, rsp_rdata_next;
  logic [27:0]        app_addr_reg, app_addr_next;
  logic [2:0]         app_cmd_reg, app_cmd_next;
  logic               app_en_reg, app_en_next;
  logic               app_wdf_wren_reg, app_wdf_wren_next;
  logic [127:0]       app_wdf_data_reg, app_wdf_data_next;
  logic [15:0]        app_wdf_mask_reg, app_wdf_mask_next;

  logic               accept;
  logic [127:0]       wdata_rep;
  logic [15:0]        be_placed;
  logic [31:0]        rd_lane;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rep
      assign wdata_rep[32*gi +: 32] = req_wdata;
    end
  endgenerate

  assign be_placed = {12'b0, req_be} << {req_addr[1:0], 2'b00};
  assign rd_lane   = app_rd_data[32*lane_reg +: 32];
  assign req_ready = (state_reg == IDLE) & init_calib_complete & ~fault_reg;
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_next        = state_reg;
    timer_next        = timer_reg;
    lane_next         = lane_reg;
    fault_next        = fault_reg;
    rsp_valid_next    = 1'b0;
    rsp_err_next      = 1'b0;
    rsp_rdata_next    = rsp_rdata_reg;
    app_addr_next     = app_addr_reg;
    app_cmd_next      = app_cmd_reg;
    app_en_next       = app_en_reg;
    app_wdf_wren_next = app_wdf_wren_reg;
    app_wdf_data_next = app_wdf_data_reg;
    app_wdf_mask_next = app_wdf_mask_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          lane_next     = req_addr[1:0];
          app_addr_next = 28'({req_addr[WADDR_W-1:2], 3'b000});
          app_en_next   = 1'b1;
          if (req_we) begin
            app_cmd_next      = 3'b000;
            app_wdf_wren_next = 1'b1;
            app_wdf_data_next = wdata_rep;
            app_wdf_mask_next = ~be_placed;
            state_next        = WR;
          end else begin
            app_cmd_next = 3'b001;
            state_next   = RD_CMD;
          end
        end
      end
      WR: begin
        // Command and data channels retire independently; leave once both have.
        if (app_en_reg & app_rdy)           app_en_next       = 1'b0;
        if (app_wdf_wren_reg & app_wdf_rdy) app_wdf_wren_next = 1'b0;
        if (!app_en_next && !app_wdf_wren_next) state_next = IDLE;
      end
      RD_CMD: begin
        if (app_rdy) begin
          app_en_next = 1'b0;
          timer_next  = '0;
          state_next  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (app_rd_data_valid) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = rd_lane;
          state_next     = IDLE;
        end else if (timer_reg == TMR_LAST) begin
          // Timeout is terminal: fault blocks further accepts until reset.
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
          fault_next     = 1'b1;
          state_next     = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      lane_reg         <= '0;
      fault_reg        <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_err_reg      <= 1'b0;
      rsp_rdata_reg    <= '0;
      app_addr_reg     <= '0;
      app_cmd_reg      <= '0;
      app_en_reg       <= 1'b0;
      app_wdf_wren_reg <= 1'b0;
      app_wdf_data_reg <= '0;
      app_wdf_mask_reg <= 16'hFFFF;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      lane_reg         <= lane_next;
      fault_reg        <= fault_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_err_reg      <= rsp_err_next;
      rsp_rdata_reg    <= rsp_rdata_next;
      app_addr_reg     <= app_addr_next;
      app_cmd_reg      <= app_cmd_next;
      app_en_reg       <= app_en_next;
      app_wdf_wren_reg <= app_wdf_wren_next;
      app_wdf_data_reg <= app_wdf_data_next;
      app_wdf_mask_reg <= app_wdf_mask_next;
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_rdata    = rsp_rdata_reg;
  assign rsp_err      = rsp_err_reg;
  assign fault        = fault_reg;
  assign app_addr     = app_addr_reg;
  assign app_cmd      = app_cmd_reg;
  assign app_en       = app_en_reg;
  assign app_wdf_wren = app_wdf_wren_reg;
  assign app_wdf_end  = app_wdf_wren_reg;
  assign app_wdf_data = app_wdf_data_reg;
  assign app_wdf_mask = app_wdf_mask_reg;

endmodule

// File: tb/tb_ddr3_word_port.sv
// Bench for ddr3_word_port: MIG memory model on the app side, word-level reference memory
// on the request side, and a scoreboard queue checked by an independent response monitor.
module tb_ddr3_word_port;

  localparam int RD_TO = 15;

  logic         ui_clk = 1'b0;
  logic         rst, calib;
  logic         req_valid, req_ready, req_we;
  logic [26:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic         rsp_valid, rsp_err, fault;
  logic [31:0]  rsp_rdata;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [127:0] app_wdf_data, app_rd_data;
  logic [15:0]  app_wdf_mask;
  logic         app_rd_data_valid;

  always #5 ui_clk = ~ui_clk;

  ddr3_word_port #(.WADDR_W(27), .RD_TIMEOUT(RD_TO)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(rst), .init_calib_complete(calib),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .fault(fault),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  typedef struct { logic [31:0] data; logic err; } rsp_t;
  rsp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0]  ref_mem[int];
  logic [127:0] line_mem[int];

  // MIG model controls and observations
  bit           rand_rdy = 0, wdf_stall = 0, drop_reads = 0, spurious = 0, calib_rand = 0;
  int           stall_cnt = 0, fixed_delay = 0;
  int           en_cycles = 0, wren_cycles = 0, cmd_count = 0;
  int           rd_hs_cyc = 0, rsp_cyc = 0;
  logic [27:0]  last_wr_addr = '0;
  logic [15:0]  last_wr_mask = '0;
  logic [127:0] last_wr_data = '0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(posedge ui_clk) cyc <= cyc + 1;

  always @(negedge ui_clk) if (calib_rand) begin
    #1 calib = ($urandom_range(0, 7) != 0);
  end

  // MIG model
  bit           pend_cmd, pend_dat, prev_en_stall, prev_wren_stall;
  logic [27:0]  pend_addr, rd_addr;
  logic [127:0] pend_data;
  logic [15:0]  pend_mask;
  logic [30:0]  prev_cmd_addr;
  logic [143:0] prev_wd;
  int           rd_cnt;
  initial begin
    app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0; app_rd_data = '0;
    pend_cmd = 0; pend_dat = 0; prev_en_stall = 0; prev_wren_stall = 0; rd_cnt = 0;
  end

  always @(negedge ui_clk) begin
    if (rst) begin
      pend_cmd = 0; pend_dat = 0; rd_cnt = 0; app_rd_data_valid = 0;
      app_rdy = 1; app_wdf_rdy = 1; prev_en_stall = 0; prev_wren_stall = 0;
    end else begin
      if (prev_en_stall) begin
        chk("en_hold", app_en, 1);
        chk("cmd_addr_hold", {app_cmd, app_addr}, prev_cmd_addr);
      end
      if (prev_wren_stall) chk("wdf_hold", {app_wdf_mask, app_wdf_data}, prev_wd);
      if (app_wdf_wren || app_wdf_end) chk("wdf_end", app_wdf_end, app_wdf_wren);

      app_rd_data_valid = 0;
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      if (spurious) begin
        app_rd_data_valid = 1;
        spurious = 0;
      end else if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          app_rd_data_valid = 1;
          app_rd_data = line_mem.exists(int'(rd_addr)) ? line_mem[int'(rd_addr)] : '0;
        end
      end

      if (app_en && stall_cnt > 0) begin
        app_rdy = 0;
        stall_cnt--;
      end else app_rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      app_wdf_rdy = wdf_stall ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);

      if (app_en)       en_cycles++;
      if (app_wdf_wren) wren_cycles++;
      prev_en_stall   = app_en && !app_rdy;
      prev_cmd_addr   = {app_cmd, app_addr};
      prev_wren_stall = app_wdf_wren && !app_wdf_rdy;
      prev_wd         = {app_wdf_mask, app_wdf_data};

      if (app_en && app_rdy) begin
        cmd_count++;
        if (app_cmd == 3'b001) begin
          rd_addr   = app_addr;
          rd_hs_cyc = cyc;
          if (!drop_reads) rd_cnt = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 8);
        end else begin
          chk("wr_cmd", app_cmd, 3'b000);
          pend_cmd = 1; pend_addr = app_addr; last_wr_addr = app_addr;
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        pend_dat = 1; pend_data = app_wdf_data; pend_mask = app_wdf_mask;
        last_wr_data = app_wdf_data; last_wr_mask = app_wdf_mask;
      end
      if (pend_cmd && pend_dat) begin
        logic [127:0] line;
        line = line_mem.exists(int'(pend_addr)) ? line_mem[int'(pend_addr)] : '0;
        for (int b = 0; b < 16; b++) if (!pend_mask[b]) line[8*b +: 8] = pend_data[8*b +: 8];
        line_mem[int'(pend_addr)] = line;
        pend_cmd = 0; pend_dat = 0;
      end
    end
  end

  // Response monitor
  always @(negedge ui_clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got rdata=%08h err=%0b want no response", rsp_rdata, rsp_err);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_err", rsp_err, e.err);
        rsp_cyc = cyc;
      end
    end
  end

  function automatic void ref_write(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a)] = w;
  endfunction

  task automatic issue(input logic we, input logic [26:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit upd);
    int n = 0;
    rsp_t e;
    @(negedge ui_clk); #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    #1;
    while (!req_ready && n < 300) begin
      @(negedge ui_clk); #2; n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1);
    end else begin
      $display("txn we=%0b addr=%07h wdata=%08h be=%h", we, a, d, be);
      if (we) begin
        if (upd) ref_write(a, d, be);
      end else begin
        e.err  = drop_reads;
        e.data = drop_reads ? 32'h0 : (ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0);
        exp_q.push_back(e);
      end
      @(posedge ui_clk);
    end
    #1 req_valid = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge ui_clk); n++;
    end
    #2 chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cc;
    rst = 1; calib = 0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge ui_clk);
    #1 rst = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren_end", {app_wdf_wren, app_wdf_end}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_fault", fault, 0);
    chk("rst_mask", app_wdf_mask, 16'hFFFF);
    chk("rst_addr_cmd", {app_addr, app_cmd}, 0);
    chk("rst_wdata", app_wdf_data, 0);

    // Calibration gating, then first write at lane 2
    req_valid = 1; req_we = 1; req_addr = 27'h6; req_wdata = 32'hDEADBEEF; req_be = 4'b0011;
    repeat (4) begin
      @(negedge ui_clk); #2;
      chk("nocal_ready", req_ready, 0);
      chk("nocal_en", app_en, 0);
    end
    en_cycles = 0; wren_cycles = 0; cmd_count = 0;
    calib = 1;
    #1 chk("cal_ready", req_ready, 1);
    $display("txn we=1 addr=0000006 wdata=deadbeef be=3");
    ref_write(27'h6, 32'hDEADBEEF, 4'b0011);
    @(posedge ui_clk); #1 req_valid = 0;
    repeat (6) @(negedge ui_clk);
    #2;
    chk("wr_app_addr", last_wr_addr, 28'h0000008);
    chk("wr_mask", last_wr_mask, 16'hFCFF);
    chk("wr_data", last_wr_data, {4{32'hDEADBEEF}});
    chk("wr_en_cycles", en_cycles, 1);
    chk("wr_wren_cycles", wren_cycles, 1);
    chk("wr_cmd_count", cmd_count, 1);
    chk("wr_back_idle", req_ready, 1);

    // Command channel stalled 5 cycles, data channel free
    en_cycles = 0; wren_cycles = 0; cmd_count = 0; stall_cnt = 5;
    issue(1, 27'h10, $urandom, 4'hF, 1);
    repeat (12) @(negedge ui_clk);
    #2;
    chk("stall_en_cycles", en_cycles, 6);
    chk("stall_wren_cycles", wren_cycles, 1);
    chk("stall_cmd_count", cmd_count, 1);

    // Read from lane 3 with a 10-cycle data latency
    line_mem[0] = 128'h44444444_33333333_22222222_11111111;
    ref_mem[0] = 32'h11111111; ref_mem[1] = 32'h22222222;
    ref_mem[2] = 32'h33333333; ref_mem[3] = 32'h44444444;
    fixed_delay = 10;
    issue(0, 27'h3, 32'h0, 4'h0, 1);
    wait_drain();
    fixed_delay = 0;

    // Reset while a write is stalled on both channels
    stall_cnt = 1000; wdf_stall = 1;
    issue(1, 27'h20, 32'hCAFEF00D, 4'hF, 0);
    repeat (3) @(negedge ui_clk);
    cc = cmd_count;
    #1 rst = 1;
    @(negedge ui_clk);
    #1 rst = 0; stall_cnt = 0; wdf_stall = 0;
    #1;
    chk("rstwr_app_en", app_en, 0);
    chk("rstwr_wren", app_wdf_wren, 0);
    chk("rstwr_idle", req_ready, 1);
    repeat (4) @(negedge ui_clk);
    #2 chk("rstwr_no_cmd", cmd_count, cc);

    // Randomized traffic with random back-pressure and calibration drops
    rand_rdy = 1; calib_rand = 1;
    for (int i = 0; i < 150; i++) begin
      logic [26:0] a;
      logic [21:0] hi;
      case ($urandom_range(0, 3))
        0: hi = 22'h0;
        1: hi = 22'h000001;
        2: hi = 22'h12345;
        default: hi = 22'h3FFFFF;
      endcase
      a = {hi, 5'($urandom_range(0, 31))};
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1);
    end
    wait_drain();
    calib_rand = 0; rand_rdy = 0;
    @(negedge ui_clk); #3 calib = 1;

    // Read timeout, fault latch, ignored stray read data, reset recovery
    drop_reads = 1;
    issue(0, 27'h40, 32'h0, 4'h0, 1);
    wait_drain();
    chk("to_latency", rsp_cyc - rd_hs_cyc, RD_TO + 1);
    chk("to_fault", fault, 1);
    chk("to_ready", req_ready, 0);
    drop_reads = 0;
    spurious = 1;
    repeat (6) @(negedge ui_clk);
    #1 rst = 1;
    @(negedge ui_clk);
    #1 rst = 0;
    #1;
    chk("rst_clears_fault", fault, 0);
    chk("rst_ready_again", req_ready, 1);
    issue(0, 27'h6, 32'h0, 4'h0, 1);
    wait_drain();
    spurious = 1;
    repeat (6) @(negedge ui_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
